// File: rtl/multu_seq_hilo.sv
// Issue sequencer and architectural HI/LO registers for the iterative unsigned multiplier.
// Runs ITER iteration cycles, one result-out cycle, then captures (or accumulates) the product.
module multu_seq_hilo #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [63:0] mul_product,
  output logic [5:0]  mul_signal,
  output logic [31:0] mul_dataA,
  output logic [31:0] mul_dataB,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int CW = $clog2(ITER) + 1;

  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MADDU = 6'd28;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;

  typedef enum logic [1:0] {IDLE, RUN, OUT, CAP} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   op_a_reg;
  logic [31:0]   op_b_reg;
  logic          is_maddu_reg;
  logic [31:0]   hi_reg;
  logic [31:0]   lo_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      is_maddu_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (op_valid) begin
            case (funct)
              F_MULTU, F_MADDU: begin
                op_a_reg     <= op_a;
                op_b_reg     <= op_b;
                is_maddu_reg <= (funct == F_MADDU);
                cnt_reg      <= '0;
                state_reg    <= RUN;
              end
              F_MTHI:  hi_reg <= op_a;
              F_MTLO:  lo_reg <= op_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(ITER - 1))
            state_reg <= OUT;
        end
        OUT: state_reg <= CAP;
        CAP: begin
          // The multiplier returns only the raw product; the accumulate happens here.
          if (is_maddu_reg)
            {hi_reg, lo_reg} <= {hi_reg, lo_reg} + mul_product;
          else
            {hi_reg, lo_reg} <= mul_product;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Control code and stall are decoded from registered state only.
  always_comb begin
    mul_signal = 6'd0;
    unique case (state_reg)
      RUN:     mul_signal = is_maddu_reg ? 6'd28 : 6'd25;
      OUT:     mul_signal = is_maddu_reg ? 6'd62 : 6'd63;
      default: mul_signal = 6'd0;
    endcase
  end

  always_comb begin
    rd_data = 32'd0;
    if (op_valid) begin
      case (funct)
        F_MFHI:  rd_data = hi_reg;
        F_MFLO:  rd_data = lo_reg;
        default: rd_data = 32'd0;
      endcase
    end
  end

  assign stall     = (state_reg != IDLE);
  assign mul_dataA = op_a_reg;
  assign mul_dataB = op_b_reg;
  assign hi        = hi_reg;
  assign lo        = lo_reg;

endmodule

// File: tb/tb_multu_seq_hilo.sv
// Directed bench for multu_seq_hilo with a behavioural multiplier stub and an expected-HI/LO scoreboard.
`timescale 1ns/1ps
module tb_multu_seq_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] mul_product;
  logic [5:0]  mul_signal;
  logic [31:0] mul_dataA;
  logic [31:0] mul_dataB;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;
  logic [5:0]  it_cnt;

  multu_seq_hilo #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .funct(funct),
    .op_a(op_a), .op_b(op_b), .mul_product(mul_product),
    .mul_signal(mul_signal), .mul_dataA(mul_dataA), .mul_dataB(mul_dataB),
    .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Multiplier stub: yields a valid product only after exactly 32 iteration cycles.
  always @(posedge clk) begin
    if (reset) begin
      mul_product <= 64'd0;
      it_cnt      <= 6'd0;
    end else if (mul_signal == 6'd25 || mul_signal == 6'd28) begin
      it_cnt <= it_cnt + 6'd1;
    end else if (mul_signal == 6'd63 || mul_signal == 6'd62) begin
      mul_product <= (it_cnt == 6'd32) ? ({32'd0, mul_dataA} * {32'd0, mul_dataB})
                                       : 64'hDEAD_BEEF_DEAD_BEEF;
      it_cnt <= 6'd0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; funct = f; op_a = a; op_b = b;
    cyc();
    op_valid = 1'b0; funct = 6'd0;
  endtask

  task automatic move_to(input string tag, input logic [5:0] f, input logic [31:0] a);
    issue(f, a, 32'd0);
    if (f == 6'd17) m_hi = a; else m_lo = a;
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    check({tag, "_stall"}, {63'd0, stall}, 64'd0);
  endtask

  task automatic move_from(input string tag, input logic [5:0] f, input logic [31:0] exp);
    op_valid = 1'b1; funct = f;
    #1;
    check(tag, {32'd0, rd_data}, {32'd0, exp});
    cyc();
    op_valid = 1'b0; funct = 6'd0;
    check({tag, "_nostall"}, {63'd0, stall}, 64'd0);
  endtask

  task automatic run_mul(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic inject);
    int st, itc, outc, capc, badc;
    logic [5:0] itcode, outcode;
    logic [63:0] prod, exp;
    st = 0; itc = 0; outc = 0; capc = 0; badc = 0;
    itcode  = (f == 6'd28) ? 6'd28 : 6'd25;
    outcode = (f == 6'd28) ? 6'd62 : 6'd63;
    prod = {32'd0, a} * {32'd0, b};
    exp  = (f == 6'd28) ? ({m_hi, m_lo} + prod) : prod;
    sb_q.push_back(exp);
    {m_hi, m_lo} = exp;
    issue(f, a, b);
    while (stall === 1'b1 && st < 100) begin
      st++;
      if (mul_signal == itcode && outc == 0) itc++;
      else if (mul_signal == outcode && itc == 32 && outc == 0) outc++;
      else if (mul_signal == 6'd0 && outc == 1) capc++;
      else badc++;
      if (inject) begin
        op_valid = 1'b1; funct = 6'd19; op_a = 32'h55; op_b = 32'h66;
      end
      cyc();
    end
    op_valid = 1'b0; funct = 6'd0;
    check({tag, "_stall_cycles"}, 64'(st), 64'd34);
    check({tag, "_iter_cycles"}, 64'(itc), 64'd32);
    check({tag, "_out_cycles"}, 64'(outc), 64'd1);
    check({tag, "_cap_cycles"}, 64'(capc), 64'd1);
    check({tag, "_bad_codes"}, 64'(badc), 64'd0);
    check({tag, "_dataA_held"}, {32'd0, mul_dataA}, {32'd0, a});
    check({tag, "_dataB_held"}, {32'd0, mul_dataB}, {32'd0, b});
    if (sb_q.size() == 0) check({tag, "_sb_empty"}, 64'd1, 64'd0);
    else check({tag, "_hilo"}, {hi, lo}, sb_q.pop_front());
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; funct = 6'd0; op_a = 32'd0; op_b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    cyc(); cyc();
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_signal", {58'd0, mul_signal}, 64'd0);
    check("rst_rd_data", {32'd0, rd_data}, 64'd0);
    check("rst_dataA", {32'd0, mul_dataA}, 64'd0);
    reset = 1'b0;
    cyc();

    run_mul("multu_max", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    // Back-to-back: issued in the first IDLE cycle after capture.
    run_mul("multu_b2b", 6'd25, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    move_to("mthi_1", 6'd17, 32'd1);
    move_to("mtlo_2", 6'd19, 32'd2);
    run_mul("maddu_3x4", 6'd28, 32'd3, 32'd4, 1'b0);
    move_from("mflo_e", 6'd18, 32'h0000_000E);
    move_from("mfhi_1", 6'd16, 32'h0000_0001);

    move_to("mthi_ff", 6'd17, 32'hFFFF_FFFF);
    move_to("mtlo_ff", 6'd19, 32'hFFFF_FFFF);
    run_mul("maddu_wrap", 6'd28, 32'd1, 32'd1, 1'b0);

    run_mul("maddu_big", 6'd28, 32'hDEAD_0001, 32'h0BAD_F00D, 1'b0);

    // Reset during RUN aborts with no HI/LO write beyond the reset clear.
    issue(6'd25, 32'd5, 32'd5);
    for (int i = 0; i < 9; i++) cyc();
    check("abort_in_run", {58'd0, mul_signal}, 64'd25);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    sb_q.push_back(64'd0);
    check("abort_stall", {63'd0, stall}, 64'd0);
    check("abort_signal", {58'd0, mul_signal}, 64'd0);
    check("abort_hilo", {hi, lo}, sb_q.pop_front());
    run_mul("multu_6x7", 6'd25, 32'd6, 32'd7, 1'b0);

    // MTLO offered throughout the stall must be ignored.
    run_mul("mtlo_in_stall", 6'd25, 32'h0001_0003, 32'h0000_0100, 1'b1);
    move_from("mflo_after", 6'd18, m_lo);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
